// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian request front end: FSM state codes and
// elaboration-time helpers for turning millisecond timings into cycle counts.
package ped_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] LOCKOUT = 2'd2;

  function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
    return (freq / 1000) * ms;
  endfunction

  // Counter holds 0..cycles-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce counter: btn_clean follows the synchronised
// button only after it has differed from btn_clean for DB_CYCLES consecutive cycles.
module btn_debounce
  import ped_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_clean
);

  localparam int unsigned CNT_W = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      btn_clean <= 1'b0;
    end else if (sync2 == btn_clean) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt       <= '0;
      btn_clean <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ped_request_frontend.sv
// Pedestrian button front end: debounced press latches a request held until ped_ack,
// followed by a lockout window. Optional req_count output under PED_REQ_COUNT_EN.
module ped_request_frontend
  import ped_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 1_000_000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LOCKOUT_MS  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       ped_ack,
  output logic       ped_req,
  output logic       btn_clean,
  output logic       lockout
`ifdef PED_REQ_COUNT_EN
  ,
  output logic [7:0] req_count
`endif
);

  localparam int unsigned DB_CYCLES = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
  localparam int unsigned LK_CYCLES = ms_to_cycles(CLK_FREQ, LOCKOUT_MS);
  localparam int unsigned LK_W      = cnt_width(LK_CYCLES);
  localparam logic [LK_W-1:0] LK_MAX = LK_W'(LK_CYCLES - 1);

  if (DB_CYCLES == 0) begin : g_bad_db_cycles
    $error("ped_request_frontend: debounce cycle count evaluates to 0");
  end
  if (LK_CYCLES == 0) begin : g_bad_lk_cycles
    $error("ped_request_frontend: lockout cycle count evaluates to 0");
  end

  logic            clean_prev;
  logic            press;
  logic [1:0]      state;
  logic [1:0]      state_next;
  logic [LK_W-1:0] lk_cnt;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_debounce (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_clean(btn_clean)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clean_prev <= 1'b0;
    end else begin
      clean_prev <= btn_clean;
    end
  end

  // Holding the button through lockout leaves clean_prev high, so no new press appears.
  assign press = btn_clean & ~clean_prev;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (press) state_next = REQ;
      REQ:     if (ped_ack) state_next = LOCKOUT;
      LOCKOUT: if (lk_cnt == LK_MAX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_cnt <= '0;
    end else if (state == REQ && ped_ack) begin
      lk_cnt <= '0;
    end else if (state == LOCKOUT) begin
      lk_cnt <= (lk_cnt == LK_MAX) ? '0 : lk_cnt + 1'b1;
    end
  end

  assign ped_req = (state == REQ);
  assign lockout = (state == LOCKOUT);

`ifdef PED_REQ_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_count <= 8'd0;
    end else if (state == IDLE && press && req_count != 8'd255) begin
      req_count <= req_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ped_request_frontend.sv
// Bench for ped_request_frontend: directed and random button/ack stimulus checked each
// cycle against a behavioural model of request, debounce and lockout timing.
module tb_ped_request_frontend;

  localparam int DB = 20;
  localparam int LK = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic ped_ack = 1'b0;
  logic ped_req;
  logic btn_clean;
  logic lockout;
`ifdef PED_REQ_COUNT_EN
  logic [7:0] req_count;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Model state: button delayed by two cycles, run length of disagreement,
  // pending request flag and remaining lockout cycles.
  bit m_s1, m_s2, m_clean, m_rose, m_req;
  int m_run, m_lock, m_cnt;

  always #5 clk = ~clk;

  ped_request_frontend #(
    .CLK_FREQ   (1000),
    .DEBOUNCE_MS(20),
    .LOCKOUT_MS (2000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .ped_ack  (ped_ack),
    .ped_req  (ped_req),
    .btn_clean(btn_clean),
    .lockout  (lockout)
`ifdef PED_REQ_COUNT_EN
    ,
    .req_count(req_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cycle=%0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_clean = 0; m_rose = 0; m_req = 0;
    m_run = 0; m_lock = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit b, input bit a);
    bit rose_now;
    rose_now = 0;
    if (m_lock > 0) begin
      m_lock--;
    end else if (m_req) begin
      if (a) begin
        m_req  = 0;
        m_lock = LK;
      end
    end else if (m_rose) begin
      m_req = 1;
      if (m_cnt < 255) m_cnt++;
    end
    if (m_s2 != m_clean) begin
      m_run++;
      if (m_run == DB) begin
        m_clean  = m_s2;
        m_run    = 0;
        rose_now = m_clean;
      end
    end else begin
      m_run = 0;
    end
    m_rose = rose_now;
    m_s2   = m_s1;
    m_s1   = b;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else model_edge(btn_raw, ped_ack);
    #1;
    check("ped_req", ped_req, m_req);
    check("btn_clean", btn_clean, m_clean);
    check("lockout", lockout, m_lock > 0);
`ifdef PED_REQ_COUNT_EN
    check("req_count", req_count, m_cnt);
`endif
  endtask

  initial begin
    int n, first_clean, first_req, seg, seen;
    model_reset();

    // Reset state
    #12;
    check("rst_ped_req", ped_req, 0);
    check("rst_btn_clean", btn_clean, 0);
    check("rst_lockout", lockout, 0);
    @(negedge clk);
    rst = 1'b0;

    // Clean press: btn_clean at cycle 22, ped_req at cycle 23
    btn_raw = 1'b1;
    first_clean = -1;
    first_req = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (btn_clean && first_clean < 0) first_clean = k;
      if (ped_req && first_req < 0) first_req = k;
    end
    check("press_clean_lat", first_clean, 22);
    check("press_req_lat", first_req, 23);
    repeat (50) tick();
    check("req_held", ped_req, 1);

    // Ack, then press during lockout is ignored; lockout lasts LK cycles
    ped_ack = 1'b1;
    tick();
    ped_ack = 1'b0;
    check("ack_req_drop", ped_req, 0);
    check("ack_lockout", lockout, 1);
    n = 0;
    while (lockout && n < LK + 100) begin
      n++;
      if (n == 1) btn_raw = 1'b0;
      if (n == 500) btn_raw = 1'b1;
      if (n == 600) btn_raw = 1'b0;
      tick();
    end
    check("lockout_len", n, LK);
    repeat (50) tick();
    check("lockout_press_ignored", ped_req, 0);

    // Press after lockout, then hold through a full lockout
    btn_raw = 1'b1;
    n = 0;
    while (!ped_req && n < 40) begin
      n++;
      tick();
    end
    check("relatch_lat", n, 23);
    ped_ack = 1'b1;
    tick();
    ped_ack = 1'b0;
    n = 0;
    while (lockout && n < LK + 100) begin
      n++;
      tick();
    end
    check("held_lockout_len", n, LK);
    repeat (100) tick();
    check("held_no_req", ped_req, 0);
    btn_raw = 1'b0;
    repeat (40) tick();

    // Bounce: toggle every 5 cycles for 60 cycles, never debounced
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      btn_raw = ((i / 5) % 2 == 0);
      tick();
      if (btn_clean || ped_req) seen++;
    end
    btn_raw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (btn_clean || ped_req) seen++;
    end
    check("bounce_quiet", seen, 0);

    // Press event and ped_ack in the same IDLE cycle: press wins
    btn_raw = 1'b1;
    n = 0;
    while (!btn_clean && n < 40) begin
      n++;
      tick();
    end
    ped_ack = 1'b1;
    tick();
    ped_ack = 1'b0;
    check("simul_req", ped_req, 1);
    repeat (10) tick();
    check("simul_hold", ped_req, 1);

    // Asynchronous reset mid-REQ with button held
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ped_req", ped_req, 0);
    check("arst_btn_clean", btn_clean, 0);
    check("arst_lockout", lockout, 0);
    model_reset();
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!ped_req && n < 40) begin
      n++;
      tick();
    end
    check("arst_relatch_lat", n, 23);

    // Random button segments and sporadic acks
    seg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        btn_raw = 1'($urandom_range(0, 1));
        seg = int'($urandom_range(1, 40));
      end
      seg--;
      ped_ack = ($urandom_range(0, 15) == 0);
      tick();
    end
    ped_ack = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
